// File: rtl/ultrasonic_transmitter.sv
// Ultrasonic transmitter: produces a fixed-length, dead-time separated square-wave
// burst on the transducer H-bridge. A hold-off window (GUARD) follows each burst
// while the echo arrives. All outputs are registered, and each output is decoded
// from the next-state values so that it lines up with the state it describes.
module ultrasonic_transmitter #(
  parameter int HALF_PERIOD  = 625,
  parameter int DEAD_TIME    = 25,
  parameter int BURST_CYCLES = 8,
  parameter int HOLDOFF      = 500000
) (
  input  logic        SYS_CLK,
  input  logic        RST_N,
  input  logic        ON,
  input  logic        TRIGGER,
  input  logic        AUTO,
  output logic        TX_P,
  output logic        TX_N,
  output logic        BURST_SENT,
  output logic        BUSY,
  output logic [15:0] BURST_COUNT
);

  typedef enum logic [1:0] {IDLE, BURST, GUARD} state_t;

  localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);
  localparam logic [16:0] DEAD_LEN  = 17'(DEAD_TIME);
  localparam logic [7:0]  CYC_LAST  = 8'(BURST_CYCLES - 1);
  localparam logic [23:0] HOLD_LAST = 24'(HOLDOFF - 1);
  localparam logic        PH_A      = 1'b0;
  localparam logic        PH_B      = 1'b1;

  state_t      state, state_d;
  logic [15:0] half_cnt, half_cnt_d;
  logic        phase, phase_d;
  logic [7:0]  cyc_cnt, cyc_cnt_d;
  logic [23:0] hold_cnt, hold_cnt_d;
  logic [15:0] burst_count_d;
  logic        trig_prev;
  logic        start;
  logic        burst_done;
  logic        guard_done;
  logic        launch;
  logic        in_dead_d;

  // Trigger edges only count while IDLE; edges seen in BURST/GUARD are dropped.
  assign start      = ON & ~trig_prev & TRIGGER & (state == IDLE);
  assign burst_done = (state == BURST) & (phase == PH_B) &
                      (half_cnt == HALF_LAST) & (cyc_cnt == CYC_LAST);
  assign guard_done = (state == GUARD) & (hold_cnt == HOLD_LAST);
  // A burst starts either from an IDLE trigger edge or as an AUTO re-fire.
  assign launch     = start | (ON & AUTO & guard_done);
  // half_cnt_d < DEAD_TIME, written as (x+1 <= DEAD) so DEAD_TIME=0 stays a plain compare.
  assign in_dead_d  = ({1'b0, half_cnt_d} + 17'd1) <= DEAD_LEN;

  // Next-state and counter update rules for the IDLE/BURST/GUARD sequencer.
  always_comb begin
    state_d       = state;
    half_cnt_d    = half_cnt;
    phase_d       = phase;
    cyc_cnt_d     = cyc_cnt;
    hold_cnt_d    = hold_cnt;
    burst_count_d = BURST_COUNT;
    if (!ON) begin
      state_d = IDLE;
    end else if (launch) begin
      state_d    = BURST;
      half_cnt_d = 16'd0;
      phase_d    = PH_A;
      cyc_cnt_d  = 8'd0;
    end else begin
      case (state)
        BURST: begin
          if (burst_done) begin
            state_d       = GUARD;
            hold_cnt_d    = 24'd0;
            burst_count_d = BURST_COUNT + 16'd1;
          end else if (half_cnt == HALF_LAST) begin
            half_cnt_d = 16'd0;
            phase_d    = ~phase;
            if (phase == PH_B) cyc_cnt_d = cyc_cnt + 8'd1;
          end else begin
            half_cnt_d = half_cnt + 16'd1;
          end
        end
        GUARD: begin
          if (guard_done) state_d = IDLE;
          else            hold_cnt_d = hold_cnt + 24'd1;
        end
        default: ;
      endcase
    end
  end

  // State, counters and registered outputs; drives decode from the next phase so
  // TX_P and TX_N can never be high together, even across state changes.
  always_ff @(posedge SYS_CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      half_cnt    <= 16'd0;
      phase       <= PH_A;
      cyc_cnt     <= 8'd0;
      hold_cnt    <= 24'd0;
      trig_prev   <= 1'b0;
      TX_P        <= 1'b0;
      TX_N        <= 1'b0;
      BURST_SENT  <= 1'b0;
      BUSY        <= 1'b0;
      BURST_COUNT <= 16'd0;
    end else begin
      state       <= state_d;
      half_cnt    <= half_cnt_d;
      phase       <= phase_d;
      cyc_cnt     <= cyc_cnt_d;
      hold_cnt    <= hold_cnt_d;
      trig_prev   <= TRIGGER;
      BURST_COUNT <= burst_count_d;
      BURST_SENT  <= launch;
      BUSY        <= (state_d != IDLE);
      TX_P        <= (state_d == BURST) & ~in_dead_d & (phase_d == PH_A);
      TX_N        <= (state_d == BURST) & ~in_dead_d & (phase_d == PH_B);
    end
  end

endmodule

// File: tb/tb_ultrasonic_transmitter.sv
// Testbench for ultrasonic_transmitter: directed scenarios followed by random
// stimulus, compared every cycle against a burst-timeline reference model.
module tb_ultrasonic_transmitter;

  localparam int HP   = 5;
  localparam int DT   = 1;
  localparam int BC   = 2;
  localparam int HO   = 10;
  localparam int BLEN = 2 * HP * BC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        on = 1'b0;
  logic        trig = 1'b0;
  logic        auto_en = 1'b0;
  logic        tx_p, tx_n, sent, busy;
  logic [15:0] count;
  logic        tx_p0, tx_n0, sent0, busy0;
  logic [15:0] count0;

  int          n_checks = 0;
  int          n_fail = 0;

  // Reference model: a burst is a timeline indexed by cycles since its start.
  bit          m_active = 1'b0;
  int          m_e = 0;
  logic [15:0] m_cnt = 16'd0;
  logic        m_prev = 1'b0;
  logic        m_sent = 1'b0;
  bit          preset = 1'b0;

  logic        on_r = 1'b1;
  logic        auto_r = 1'b0;
  logic        trig_r = 1'b0;
  logic        rst_r = 1'b1;
  bit          pre_r = 1'b0;

  always #5 clk = ~clk;

  ultrasonic_transmitter #(
    .HALF_PERIOD(HP), .DEAD_TIME(DT), .BURST_CYCLES(BC), .HOLDOFF(HO)
  ) dut (
    .SYS_CLK(clk), .RST_N(rst_n), .ON(on), .TRIGGER(trig), .AUTO(auto_en),
    .TX_P(tx_p), .TX_N(tx_n), .BURST_SENT(sent), .BUSY(busy), .BURST_COUNT(count)
  );

  ultrasonic_transmitter #(
    .HALF_PERIOD(HP), .DEAD_TIME(0), .BURST_CYCLES(BC), .HOLDOFF(HO)
  ) dut0 (
    .SYS_CLK(clk), .RST_N(rst_n), .ON(on), .TRIGGER(trig), .AUTO(auto_en),
    .TX_P(tx_p0), .TX_N(tx_n0), .BURST_SENT(sent0), .BUSY(busy0), .BURST_COUNT(count0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected drive level from position in the burst timeline.
  function automatic logic exp_tx(input int dt, input bit phase_b);
    if (!m_active || m_e >= BLEN) return 1'b0;
    if (((m_e % (2 * HP)) >= HP) != phase_b) return 1'b0;
    return (m_e % HP) >= dt;
  endfunction

  task automatic model_edge();
    bit launch;
    if (!rst_n) begin
      m_active = 1'b0;
      m_e      = 0;
      m_cnt    = 16'd0;
      m_prev   = 1'b0;
      m_sent   = 1'b0;
      return;
    end
    if (preset) m_cnt = 16'hFFFF;
    launch = 1'b0;
    if (!on) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (trig && !m_prev) launch = 1'b1;
    end else begin
      m_e++;
      if (m_e == BLEN) m_cnt = m_cnt + 16'd1;
      if (m_e == BLEN + HO) begin
        if (auto_en) launch = 1'b1;
        else m_active = 1'b0;
      end
    end
    if (launch) begin
      m_active = 1'b1;
      m_e      = 0;
    end
    m_sent = launch;
    m_prev = trig;
  endtask

  task automatic compare_all();
    chk("sent",   sent,   m_sent);
    chk("busy",   busy,   m_active);
    chk("tx_p",   tx_p,   exp_tx(DT, 1'b0));
    chk("tx_n",   tx_n,   exp_tx(DT, 1'b1));
    chk("count",  count,  m_cnt);
    chk("excl",   tx_p & tx_n, 1'b0);
    chk("sent0",  sent0,  m_sent);
    chk("busy0",  busy0,  m_active);
    chk("tx_p0",  tx_p0,  exp_tx(0, 1'b0));
    chk("tx_n0",  tx_n0,  exp_tx(0, 1'b1));
    chk("count0", count0, m_cnt);
    chk("excl0",  tx_p0 & tx_n0, 1'b0);
  endtask

  task automatic step(input logic r, input logic o, input logic t, input logic a,
                      input bit pre = 1'b0);
    @(negedge clk);
    rst_n   = r;
    on      = o;
    trig    = t;
    auto_en = a;
    preset  = pre;
    if (pre) begin
      force dut.burst_count_d = 16'hFFFF;
      force dut0.burst_count_d = 16'hFFFF;
    end
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (pre) begin
      release dut.burst_count_d;
      release dut0.burst_count_d;
    end
    preset = 1'b0;
  endtask

  initial begin
    // Reset, with a trigger pulse that must be ignored.
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    repeat (2) step(1, 1, 0, 0);

    // Single trigger, AUTO off.
    step(1, 1, 1, 0);
    repeat (35) step(1, 1, 0, 0);
    chk("s1_count", count, 16'd1);

    // AUTO re-fire from one trigger, then AUTO released.
    step(1, 1, 1, 1);
    repeat (100) step(1, 1, 0, 1);
    repeat (40) step(1, 1, 0, 0);

    // Retrigger pulses during BURST and GUARD.
    step(1, 1, 1, 0);
    for (int i = 0; i < 30; i++) step(1, 1, logic'(i % 3 == 0), 0);
    repeat (20) step(1, 1, 0, 0);

    // ON dropped at cycle 7 of a burst, then a full burst.
    step(1, 1, 1, 0);
    repeat (7) step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    repeat (32) step(1, 1, 0, 0);

    // Reset mid-GUARD, then counter wrap from 0xFFFF.
    step(1, 1, 1, 0);
    repeat (25) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("rst_count", count, 16'd0);
    chk("rst_busy", busy, 1'b0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0, 1'b1);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    repeat (32) step(1, 1, 0, 0);
    chk("wrap", count, 16'h0000);
    chk("wrap0", count0, 16'h0000);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) on_r = ~on_r;
      if ($urandom_range(0, 199) == 0) auto_r = ~auto_r;
      if ($urandom_range(0, 9) == 0) trig_r = ~trig_r;
      rst_r = ($urandom_range(0, 999) != 0);
      pre_r = !on_r && ($urandom_range(0, 49) == 0);
      step(rst_r, on_r, trig_r, auto_r, pre_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
